// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter that shares one word-wide lower memory port between the
// CPU instruction-fetch port and its data port, one latched transaction at a time.
module mem_port_arbiter #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 16,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  // instruction side
  input  logic                  i_read,
  input  logic [ADDR_WIDTH-1:0] i_address,
  output logic [DATA_WIDTH-1:0] i_rdata,
  output logic                  i_resp,
  // data side
  input  logic                  d_read,
  input  logic                  d_write,
  input  logic [ADDR_WIDTH-1:0] d_address,
  input  logic [DATA_WIDTH-1:0] d_wdata,
  input  logic [1:0]            d_byte_enable,
  output logic [DATA_WIDTH-1:0] d_rdata,
  output logic                  d_resp,
  // lower memory port
  output logic                  pmem_read,
  output logic                  pmem_write,
  output logic [ADDR_WIDTH-1:0] pmem_address,
  output logic [DATA_WIDTH-1:0] pmem_wdata,
  output logic [1:0]            pmem_byte_enable,
  input  logic [DATA_WIDTH-1:0] pmem_rdata,
  input  logic                  pmem_resp,
  // statistics and debug
  output logic [CNT_WIDTH-1:0]  conflict_count,
  output logic [1:0]            o_dbg_state
);

  // Handshake: CPU requests are levels held until the matching resp pulse;
  // the lower port sees a held strobe until pmem_resp, then the strobe drops
  // at that same edge and resp pulses for the single DONE cycle that follows.

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_BUSY_I = 2'd1,
    ST_BUSY_D = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  localparam logic GRANT_I = 1'b0;
  localparam logic GRANT_D = 1'b1;
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic                    r_last_grant;
  logic [CNT_WIDTH-1:0]    r_conflict_cnt;
  logic [ADDR_WIDTH-1:0]   r_addr;
  logic [DATA_WIDTH-1:0]   r_wdata;
  logic [1:0]              r_be;
  logic                    r_pmem_read;
  logic                    r_pmem_write;
  logic [DATA_WIDTH-1:0]   r_i_rdata;
  logic [DATA_WIDTH-1:0]   r_d_rdata;
  logic                    r_i_resp;
  logic                    r_d_resp;

  logic                    w_d_req;
  logic                    w_grant_i;
  logic                    w_grant_d;
  logic                    w_conflict;
  logic                    w_busy_done;

  assign w_d_req = d_read | d_write;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_grant_i   = 1'b0;
    w_grant_d   = 1'b0;
    w_conflict  = 1'b0;
    w_busy_done = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (i_read && w_d_req) begin
          w_conflict = 1'b1;
          if (r_last_grant == GRANT_I) begin
            w_grant_d = 1'b1;
          end else begin
            w_grant_i = 1'b1;
          end
        end else if (i_read) begin
          w_grant_i = 1'b1;
        end else if (w_d_req) begin
          w_grant_d = 1'b1;
        end
        if (w_grant_i) begin
          w_state_nxt = ST_BUSY_I;
        end else if (w_grant_d) begin
          w_state_nxt = ST_BUSY_D;
        end
      end
      ST_BUSY_I, ST_BUSY_D: begin
        if (pmem_resp) begin
          w_busy_done = 1'b1;
          w_state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        // Requests are deliberately not looked at here so a still-held
        // request is not granted a second time.
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_last_grant   <= GRANT_I;
      r_conflict_cnt <= '0;
      r_addr         <= '0;
      r_wdata        <= '0;
      r_be           <= '0;
      r_pmem_read    <= 1'b0;
      r_pmem_write   <= 1'b0;
      r_i_rdata      <= '0;
      r_d_rdata      <= '0;
      r_i_resp       <= 1'b0;
      r_d_resp       <= 1'b0;
    end else begin
      if (w_conflict && (r_conflict_cnt != '1)) begin
        r_conflict_cnt <= r_conflict_cnt + CNT_ONE;
      end

      if (w_grant_i) begin
        r_last_grant <= GRANT_I;
        r_addr       <= i_address;
        r_be         <= 2'b11;
        r_pmem_read  <= 1'b1;
        r_pmem_write <= 1'b0;
      end else if (w_grant_d) begin
        // A simultaneous read and write is treated as a write.
        r_last_grant <= GRANT_D;
        r_addr       <= d_address;
        r_wdata      <= d_wdata;
        r_be         <= d_write ? d_byte_enable : 2'b11;
        r_pmem_read  <= ~d_write;
        r_pmem_write <= d_write;
      end else if (w_busy_done) begin
        r_pmem_read  <= 1'b0;
        r_pmem_write <= 1'b0;
        if (r_pmem_read) begin
          if (r_last_grant == GRANT_I) begin
            r_i_rdata <= pmem_rdata;
          end else begin
            r_d_rdata <= pmem_rdata;
          end
        end
      end

      r_i_resp <= w_busy_done && (r_last_grant == GRANT_I);
      r_d_resp <= w_busy_done && (r_last_grant == GRANT_D);
    end
  end

  assign pmem_read        = r_pmem_read;
  assign pmem_write       = r_pmem_write;
  assign pmem_address     = r_addr;
  assign pmem_wdata       = r_wdata;
  assign pmem_byte_enable = r_be;
  assign i_rdata          = r_i_rdata;
  assign d_rdata          = r_d_rdata;
  assign i_resp           = r_i_resp;
  assign d_resp           = r_d_resp;
  assign conflict_count   = r_conflict_cnt;
  assign o_dbg_state      = r_state;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: a latency-programmable memory responder,
// a monitor scoreboarding lower-port transactions and CPU responses in order.
module tb_mem_port_arbiter;

  localparam int DW = 16;
  localparam int AW = 16;
  localparam int CW = 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic          i_read;
  logic [AW-1:0] i_address;
  logic [DW-1:0] i_rdata;
  logic          i_resp;
  logic          d_read;
  logic          d_write;
  logic [AW-1:0] d_address;
  logic [DW-1:0] d_wdata;
  logic [1:0]    d_byte_enable;
  logic [DW-1:0] d_rdata;
  logic          d_resp;
  logic          pmem_read;
  logic          pmem_write;
  logic [AW-1:0] pmem_address;
  logic [DW-1:0] pmem_wdata;
  logic [1:0]    pmem_byte_enable;
  logic [DW-1:0] pmem_rdata;
  logic          pmem_resp;
  logic [CW-1:0] conflict_count;
  logic [1:0]    dbg_state;

  logic auto_resp;
  logic force_resp;
  assign pmem_resp = auto_resp | force_resp;

  mem_port_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_read(i_read), .i_address(i_address), .i_rdata(i_rdata), .i_resp(i_resp),
    .d_read(d_read), .d_write(d_write), .d_address(d_address), .d_wdata(d_wdata),
    .d_byte_enable(d_byte_enable), .d_rdata(d_rdata), .d_resp(d_resp),
    .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_address(pmem_address),
    .pmem_wdata(pmem_wdata), .pmem_byte_enable(pmem_byte_enable),
    .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp),
    .conflict_count(conflict_count), .o_dbg_state(dbg_state)
  );

  // ---------------- scoreboard state ----------------
  int n_checks = 0;
  int n_fail   = 0;
  logic [DW:0]   exp_q[$];   // {is_d, rdata}
  logic [34:0]   pm_q[$];    // {write, addr, wdata, be}
  int            resp_seen = 0;
  int            slen = 0;
  logic          resp_en;
  int            mem_lat;
  logic [DW-1:0] model_d_rdata;

  function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
    return a ^ 16'h1274;
  endfunction

  function automatic logic [34:0] pm_rec(input logic w, input logic [AW-1:0] a,
                                         input logic [DW-1:0] wd, input logic [1:0] be);
    return {w, a, wd, be};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---------------- memory responder ----------------
  initial begin : responder
    int bcnt;
    bcnt = 0;
    auto_resp  = 1'b0;
    pmem_rdata = '0;
    forever begin
      @(negedge clk);
      if (resp_en && (pmem_read || pmem_write) && !auto_resp) begin
        bcnt++;
        if (bcnt >= mem_lat) begin
          auto_resp  = 1'b1;
          pmem_rdata = mem_word(pmem_address);
        end
      end else begin
        auto_resp = 1'b0;
        bcnt      = 0;
      end
    end
  end

  // ---------------- monitor ----------------
  logic        prev_strobe = 1'b0;
  logic        strobe;
  logic [34:0] cur_pm = '0;
  logic [DW:0] cur_exp;

  initial begin : monitor
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1) begin
        chk("excl_strobe", pmem_read & pmem_write, 0);
        chk("excl_resp", i_resp & d_resp, 0);
        strobe = pmem_read | pmem_write;
        if (strobe && !prev_strobe) begin
          slen = 0;
          chk("pm_expected", pm_q.size() > 0, 1);
          if (pm_q.size() > 0) cur_pm = pm_q.pop_front();
        end
        if (strobe) begin
          slen++;
          chk("pm_write", pmem_write, cur_pm[34]);
          chk("pm_read", pmem_read, !cur_pm[34]);
          chk("pm_addr", pmem_address, cur_pm[33:18]);
          if (cur_pm[34]) chk("pm_wdata", pmem_wdata, cur_pm[17:2]);
          chk("pm_be", pmem_byte_enable, cur_pm[1:0]);
        end
        prev_strobe = strobe;
        if (i_resp || d_resp) begin
          resp_seen++;
          chk("done_strobes", strobe, 0);
          chk("resp_expected", exp_q.size() > 0, 1);
          if (exp_q.size() > 0) begin
            cur_exp = exp_q.pop_front();
            chk("resp_port", d_resp, cur_exp[DW]);
            chk("rdata", d_resp ? d_rdata : i_rdata, cur_exp[DW-1:0]);
          end
        end
      end else begin
        prev_strobe = 1'b0;
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks ----------------
  task automatic wait_resp(input int target, input int budget);
    int c;
    c = 0;
    while (resp_seen < target && c < budget) begin
      @(negedge clk); #1;
      c++;
    end
    chk("resp_wait", resp_seen, target);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_pm_strobes"}, {pmem_read, pmem_write}, 0);
    chk({tag, "_pm_addr"}, pmem_address, 0);
    chk({tag, "_pm_wdata"}, pmem_wdata, 0);
    chk({tag, "_pm_be"}, pmem_byte_enable, 0);
    chk({tag, "_resps"}, {i_resp, d_resp}, 0);
    chk({tag, "_rdata"}, {i_rdata, d_rdata}, 0);
    chk({tag, "_cnt"}, conflict_count, 0);
    chk({tag, "_state"}, dbg_state, 0);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk); #1;
    rst_n = 1'b1;
    model_d_rdata = '0;
  endtask

  // ---------------- directed sequence ----------------
  initial begin : main
    int base;
    int c;
    rst_n = 1'b0; i_read = 0; i_address = '0; d_read = 0; d_write = 0;
    d_address = '0; d_wdata = '0; d_byte_enable = '0;
    resp_en = 1'b1; mem_lat = 1; force_resp = 1'b0; model_d_rdata = '0;
    repeat (2) @(negedge clk);
    #1;
    check_reset_outputs("reset");
    rst_n = 1'b1;

    // single instruction read, memory answers on the 3rd strobe cycle
    mem_lat = 3;
    pm_q.push_back(pm_rec(1'b0, 16'h0040, 16'h0000, 2'b11));
    exp_q.push_back({1'b0, 16'h1234});
    i_read = 1; i_address = 16'h0040;
    wait_resp(1, 40);
    i_read = 0;
    chk("i_strobe_len", slen, 3);

    // data byte write
    mem_lat = 1;
    pm_q.push_back(pm_rec(1'b1, 16'h2001, 16'hAB00, 2'b10));
    exp_q.push_back({1'b1, model_d_rdata});
    @(negedge clk); #1;
    d_write = 1; d_address = 16'h2001; d_wdata = 16'hAB00; d_byte_enable = 2'b10;
    wait_resp(2, 40);
    d_write = 0;
    chk("w_strobe_len", slen, 1);

    // data read then full write: write must not disturb d_rdata
    model_d_rdata = mem_word(16'h3000);
    pm_q.push_back(pm_rec(1'b0, 16'h3000, 16'h0000, 2'b11));
    exp_q.push_back({1'b1, model_d_rdata});
    d_read = 1; d_address = 16'h3000;
    wait_resp(3, 40);
    d_read = 0;
    pm_q.push_back(pm_rec(1'b1, 16'h3002, 16'hBEEF, 2'b11));
    exp_q.push_back({1'b1, model_d_rdata});
    @(negedge clk); #1;
    d_write = 1; d_read = 1; d_address = 16'h3002; d_wdata = 16'hBEEF; d_byte_enable = 2'b11;
    wait_resp(4, 40);
    d_write = 0; d_read = 0;
    chk("cnt_no_conflict", conflict_count, 0);

    // contention after reset: D first, then alternate; counter saturates at 3
    apply_reset();
    chk("cnt_after_reset", conflict_count, 0);
    base = resp_seen;
    for (int k = 0; k < 5; k++) begin
      if (k % 2 == 0) begin
        model_d_rdata = mem_word(16'h4000);
        pm_q.push_back(pm_rec(1'b0, 16'h4000, 16'h0000, 2'b11));
        exp_q.push_back({1'b1, model_d_rdata});
      end else begin
        pm_q.push_back(pm_rec(1'b0, 16'h0080, 16'h0000, 2'b11));
        exp_q.push_back({1'b0, mem_word(16'h0080)});
      end
    end
    i_read = 1; i_address = 16'h0080; d_read = 1; d_address = 16'h4000;
    for (int k = 0; k < 5; k++) begin
      wait_resp(base + k + 1, 40);
      chk("conflict_cnt", conflict_count, (k + 1 > 3) ? 3 : k + 1);
    end
    i_read = 0; d_read = 0;
    repeat (3) @(negedge clk);
    #1;
    chk("cnt_hold", conflict_count, 3);

    // held request: i_read stays up across the DONE->IDLE edge
    mem_lat = 2;
    base = resp_seen;
    pm_q.push_back(pm_rec(1'b0, 16'h0100, 16'h0000, 2'b11));
    exp_q.push_back({1'b0, mem_word(16'h0100)});
    i_read = 1; i_address = 16'h0100;
    wait_resp(base + 1, 40);
    chk("held_done_read", pmem_read, 0);
    @(negedge clk);
    i_read = 0;
    repeat (4) @(negedge clk);
    #1;
    chk("held_single_txn", resp_seen, base + 1);
    chk("held_no_reissue", pm_q.size(), 0);
    chk("held_idle", dbg_state, 0);

    // reset while a data write is in flight, then a stray pmem_resp
    resp_en = 1'b0;
    base = resp_seen;
    pm_q.push_back(pm_rec(1'b1, 16'h5000, 16'h1234, 2'b01));
    d_write = 1; d_address = 16'h5000; d_wdata = 16'h1234; d_byte_enable = 2'b01;
    c = 0;
    while (!pmem_write && c < 20) begin
      @(negedge clk); #1;
      c++;
    end
    chk("busy_d_strobe", pmem_write, 1);
    chk("busy_d_state", dbg_state, 2);
    @(negedge clk);
    rst_n = 1'b0; d_write = 0;
    @(negedge clk); #1;
    rst_n = 1'b1;
    model_d_rdata = '0;
    check_reset_outputs("mid_rst");
    force_resp = 1'b1;
    @(negedge clk);
    force_resp = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); #1;
      chk("stray_d_resp", d_resp, 0);
    end
    chk("stray_no_resp", resp_seen, base);
    resp_en = 1'b1;

    // recovery: normal instruction read after the abandoned transaction
    mem_lat = 1;
    pm_q.push_back(pm_rec(1'b0, 16'h0ABC, 16'h0000, 2'b11));
    exp_q.push_back({1'b0, mem_word(16'h0ABC)});
    i_read = 1; i_address = 16'h0ABC;
    wait_resp(base + 1, 40);
    i_read = 0;
    repeat (3) @(negedge clk);
    #1;

    chk("exp_q_empty", exp_q.size(), 0);
    chk("pm_q_empty", pm_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
